clock_time_setter: RTL and testbench

Edit-mode controller for the digital clock's time counter. While `adjust` is high it holds an editable shadow copy of hour/minute/second (packed BCD), moves a field cursor on `left`/`right` and steps the selected field on `up`/`down` with modulo wrap. On `apply` it loads the shadow into the time counter through a req/ack handshake with timeout. It sits between the debounced button front end and the seconds/minutes/hours counter chain, and feeds the display mux with the shadow values and cursor.

---
 rtl/clock_pkg.sv | 18 +
 rtl/bcd_wrap_step.sv | 23 ++
 rtl/clock_time_setter.sv | 138 +++++++++++++
 tb/tb_clock_time_setter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the clock time-setting logic.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EDIT = 2'd1,
    ST_LOAD = 2'd2
  } state_e;

  localparam logic [2:0] FLD_SEC  = 3'b001;
  localparam logic [2:0] FLD_MIN  = 3'b010;
  localparam logic [2:0] FLD_HOUR = 3'b100;

  localparam logic [7:0] BCD_MAX_SEC  = 8'h59;
  localparam logic [7:0] BCD_MAX_MIN  = 8'h59;
  localparam logic [7:0] BCD_MAX_HOUR = 8'h23;

endpackage

// File: rtl/bcd_wrap_step.sv
// One-step BCD increment/decrement of a two-digit field, wrapping between 00 and max_i.
module bcd_wrap_step (
  input  logic [7:0] val_i,
  input  logic [7:0] max_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [7:0] nxt_o
);

  always_comb begin
    nxt_o = val_i;
    if (inc_i && !dec_i) begin
      if (val_i == max_i)            nxt_o = 8'h00;
      else if (val_i[3:0] == 4'd9)   nxt_o = {val_i[7:4] + 4'd1, 4'd0};
      else                           nxt_o = {val_i[7:4], val_i[3:0] + 4'd1};
    end else if (dec_i && !inc_i) begin
      if (val_i == 8'h00)            nxt_o = max_i;
      else if (val_i[3:0] == 4'd0)   nxt_o = {val_i[7:4] - 4'd1, 4'd9};
      else                           nxt_o = {val_i[7:4], val_i[3:0] - 4'd1};
    end
  end

endmodule

// File: rtl/clock_time_setter.sv
// Edit-mode controller: shadows the live time, edits it field by field, and
// loads it back into the time counter through a req/ack handshake with timeout.
module clock_time_setter
  import clock_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       CP,
  input  logic       _CR,
  input  logic       adjust,
  input  logic       left,
  input  logic       right,
  input  logic       up,
  input  logic       down,
  input  logic       apply,
  input  logic [7:0] cur_sec,
  input  logic [7:0] cur_min,
  input  logic [7:0] cur_hour,
  input  logic       load_ack,
  output logic       editing,
  output logic [2:0] field_sel,
  output logic [7:0] edit_sec,
  output logic [7:0] edit_min,
  output logic [7:0] edit_hour,
  output logic       load_req,
  output logic       load_err,
  output state_e     dbg_state
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            editing_q, editing_d;
  logic [2:0]      field_sel_q, field_sel_d;
  logic [7:0]      sec_q, sec_d, min_q, min_d, hour_q, hour_d;
  logic            load_req_q, load_req_d;
  logic            load_err_q, load_err_d;
  logic            step_en, inc, dec, timeout;
  logic [7:0]      sec_nxt, min_nxt, hour_nxt;

  // Buttons only act in EDIT when neither leaving nor applying this cycle.
  assign step_en = (state_q == ST_EDIT) && adjust && !apply;
  assign inc     = step_en && up && !down;
  assign dec     = step_en && down && !up;

  // Handshake: load_req rises the cycle after apply and stays high until
  // load_ack is sampled high or the timeout fires; load_ack is only observed
  // in LOAD, and an ack on the timeout cycle wins over the timeout.
  assign timeout = (state_q == ST_LOAD) && !load_ack && (cnt_q == CW'(ACK_TIMEOUT - 1));

  bcd_wrap_step u_sec (
    .val_i(sec_q), .max_i(BCD_MAX_SEC), .inc_i(inc && field_sel_q[0]),
    .dec_i(dec && field_sel_q[0]), .nxt_o(sec_nxt)
  );
  bcd_wrap_step u_min (
    .val_i(min_q), .max_i(BCD_MAX_MIN), .inc_i(inc && field_sel_q[1]),
    .dec_i(dec && field_sel_q[1]), .nxt_o(min_nxt)
  );
  bcd_wrap_step u_hour (
    .val_i(hour_q), .max_i(BCD_MAX_HOUR), .inc_i(inc && field_sel_q[2]),
    .dec_i(dec && field_sel_q[2]), .nxt_o(hour_nxt)
  );

  always_ff @(posedge CP or negedge _CR) begin
    if (!_CR) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      editing_q   <= 1'b0;
      field_sel_q <= FLD_SEC;
      sec_q       <= 8'h00;
      min_q       <= 8'h00;
      hour_q      <= 8'h00;
      load_req_q  <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      editing_q   <= editing_d;
      field_sel_q <= field_sel_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      load_req_q  <= load_req_d;
      load_err_q  <= load_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (adjust) state_d = ST_EDIT;
      ST_EDIT: begin
        if (!adjust)    state_d = ST_IDLE;
        else if (apply) state_d = ST_LOAD;
      end
      ST_LOAD: if (load_ack || timeout) state_d = adjust ? ST_EDIT : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    editing_d   = (state_d != ST_IDLE);
    load_req_d  = (state_d == ST_LOAD);
    load_err_d  = timeout;
    cnt_d       = (state_q == ST_LOAD && state_d == ST_LOAD) ? cnt_q + CW'(1) : '0;
    field_sel_d = field_sel_q;
    if (state_d == ST_IDLE || (state_d == ST_EDIT && state_q != ST_EDIT)) begin
      field_sel_d = FLD_SEC;
    end else if (step_en && right && !left) begin
      field_sel_d = {field_sel_q[1:0], field_sel_q[2]};
    end else if (step_en && left && !right) begin
      field_sel_d = {field_sel_q[0], field_sel_q[2:1]};
    end
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    if (state_q == ST_IDLE) begin
      sec_d  = cur_sec;
      min_d  = cur_min;
      hour_d = cur_hour;
    end else if (step_en) begin
      sec_d  = sec_nxt;
      min_d  = min_nxt;
      hour_d = hour_nxt;
    end
  end

  assign editing   = editing_q;
  assign field_sel = field_sel_q;
  assign edit_sec  = sec_q;
  assign edit_min  = min_q;
  assign edit_hour = hour_q;
  assign load_req  = load_req_q;
  assign load_err  = load_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_clock_time_setter.sv
// Randomised and directed bench for clock_time_setter with a behavioural model and scoreboard.
module tb_clock_time_setter;

  localparam int ACK_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       cr_n;
  logic       adjust, left, right, up, down, apply, load_ack;
  logic [7:0] cur_sec, cur_min, cur_hour;
  logic       editing, load_req, load_err;
  logic [2:0] field_sel;
  logic [7:0] edit_sec, edit_min, edit_hour;
  clock_pkg::state_e dbg_state;

  int checks = 0;
  int errors = 0;
  logic [29:0] exp_q[$];

  // Reference model state: plain integers, cursor index 0=sec 1=min 2=hour.
  int  m_s, m_m, m_h, m_cur, m_wait;
  bit  m_edit, m_load, m_err;
  int  cs, cm, ch;
  bit  rand_cur;

  always #5 clk = ~clk;

  clock_time_setter #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .CP(clk), ._CR(cr_n), .adjust(adjust), .left(left), .right(right),
    .up(up), .down(down), .apply(apply), .cur_sec(cur_sec), .cur_min(cur_min),
    .cur_hour(cur_hour), .load_ack(load_ack), .editing(editing),
    .field_sel(field_sel), .edit_sec(edit_sec), .edit_min(edit_min),
    .edit_hour(edit_hour), .load_req(load_req), .load_err(load_err),
    .dbg_state(dbg_state)
  );

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic logic [29:0] model_vec();
    logic [2:0] sel;
    sel = 3'b001 << m_cur;
    return {(m_edit || m_load), sel, to_bcd(m_s), to_bcd(m_m), to_bcd(m_h), m_load, m_err};
  endfunction

  task automatic model_reset();
    m_s = 0; m_m = 0; m_h = 0; m_cur = 0; m_wait = 0;
    m_edit = 0; m_load = 0; m_err = 0;
  endtask

  task automatic model_exit();
    m_load = 0;
    m_cur  = 0;
    m_edit = adjust;
  endtask

  task automatic model_step();
    int delta;
    m_err = 0;
    if (m_load) begin
      if (load_ack) model_exit();
      else begin
        m_wait++;
        if (m_wait == ACK_TIMEOUT) begin
          m_err = 1;
          model_exit();
        end
      end
    end else if (m_edit) begin
      if (!adjust) begin
        m_edit = 0;
        m_cur  = 0;
      end else if (apply) begin
        m_edit = 0;
        m_load = 1;
        m_wait = 0;
      end else begin
        delta = (up && !down) ? 1 : ((down && !up) ? -1 : 0);
        case (m_cur)
          0: m_s = (m_s + 60 + delta) % 60;
          1: m_m = (m_m + 60 + delta) % 60;
          default: m_h = (m_h + 24 + delta) % 24;
        endcase
        if (right && !left)      m_cur = (m_cur + 1) % 3;
        else if (left && !right) m_cur = (m_cur + 2) % 3;
      end
    end else begin
      m_s = cs; m_m = cm; m_h = ch;
      m_cur = 0;
      if (adjust) m_edit = 1;
    end
    exp_q.push_back(model_vec());
  endtask

  // Drive one cycle of inputs just after the falling edge and record the expected response.
  task automatic cycle(input logic a, input logic l, input logic r, input logic u,
                       input logic d, input logic ap, input logic ack);
    @(negedge clk);
    #1;
    cr_n = 1'b1;
    if (rand_cur) begin
      cs = $urandom_range(0, 59); cm = $urandom_range(0, 59); ch = $urandom_range(0, 23);
    end
    cur_sec = to_bcd(cs); cur_min = to_bcd(cm); cur_hour = to_bcd(ch);
    adjust = a; left = l; right = r; up = u; down = d; apply = ap; load_ack = ack;
    model_step();
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    ch = h; cm = m; cs = s;
  endtask

  // Monitor: every registered output snapshot is compared on the falling edge.
  always @(negedge clk) begin
    logic [29:0] exp, act;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      act = {editing, field_sel, edit_sec, edit_min, edit_hour, load_req, load_err};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL outputs t=%0t got ed=%b sel=%b %h:%h:%h req=%b err=%b exp ed=%b sel=%b %h:%h:%h req=%b err=%b",
                 $time, act[29], act[28:26], act[9:2], act[17:10], act[25:18], act[1], act[0],
                 exp[29], exp[28:26], exp[9:2], exp[17:10], exp[25:18], exp[1], exp[0]);
      end
    end
  end

  initial begin
    cr_n = 1'b0;
    adjust = 0; left = 0; right = 0; up = 0; down = 0; apply = 0; load_ack = 0;
    rand_cur = 0;
    set_cur(12, 34, 56);
    cur_sec = 8'h00; cur_min = 8'h00; cur_hour = 8'h00;
    model_reset();
    exp_q.push_back(model_vec());

    // Basic edit, load with ack on the third LOAD cycle.
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    repeat (3) cycle(1, 0, 0, 1, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 0, 0);

    // Wrap boundaries: hour 23 up, minute 09 up, second 00 down.
    set_cur(23, 9, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 1, 0, 0, 0);
    cycle(1, 1, 0, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 1, 1, 0, 0);
    cycle(1, 1, 1, 0, 0, 0, 0);

    // Timeout returning to EDIT, then ack on the timeout cycle.
    cycle(1, 0, 0, 0, 0, 1, 0);
    repeat (20) cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 1, 0);
    repeat (ACK_TIMEOUT - 1) cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 0, 0);

    // Timeout with adjust dropped mid-LOAD exits to IDLE.
    cycle(1, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    repeat (ACK_TIMEOUT + 2) cycle(0, 0, 0, 0, 0, 0, 0);

    // Simultaneous events.
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 1, 1, 0, 1, 0);
    cycle(1, 0, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a load.
    set_cur(7, 45, 30);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 0, 1, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    cr_n = 1'b0;
    #1;
    checks++;
    if (load_req !== 1'b0 || editing !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got req=%b ed=%b exp req=0 ed=0", load_req, editing);
    end
    model_reset();
    exp_q.push_back(model_vec());
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);

    // Randomised traffic.
    rand_cur = 1;
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 4) == 0));
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
